// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a 4-digit multiplexed 7-segment display.
// Build option SEG_BLANK_GAP_EN inserts one blank frame between owners.
module seg_display_arbiter #(
  parameter int REFRESH_DIV = 10000,
  parameter int HOLD_FRAMES = 50
) (
  input  logic        origin_clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  // state | meaning
  // IDLE  | no owner, display blank
  // OWN0  | requester 0 drives the digits
  // OWN1  | requester 1 drives the digits
  // GAP   | one blank frame between owners (SEG_BLANK_GAP_EN only)
`ifdef SEG_BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [7:0]  HOLD_MIN = 8'(HOLD_FRAMES);

  state_t      state, state_next;
  logic [15:0] div;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [7:0]  hold;
  logic        tick;
  logic        frame_end;
  logic        blank;
  logic [31:0] owner_data;
  logic [7:0]  owner_byte;

`ifdef SEG_BLANK_GAP_EN
  state_t target, target_next;
`endif

  assign tick      = (div == DIV_LAST);
  assign idx_next  = idx + 2'd1;
  assign frame_end = tick && (idx == 2'd3);

  function automatic state_t idle_pick(input logic r0, input logic r1);
    if (r1)
      return OWN1;
    else if (r0)
      return OWN0;
    else
      return IDLE;
  endfunction

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (tick) begin
      div <= '0;
      idx <= idx_next;
    end else begin
      div <= div + 16'd1;
    end
  end

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef SEG_BLANK_GAP_EN
  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= IDLE;
    end else begin
      target <= target_next;
    end
  end
`endif

  always_comb begin
    state_next = state;
`ifdef SEG_BLANK_GAP_EN
    target_next = target;
`endif
    if (frame_end) begin
      case (state)
        IDLE: state_next = idle_pick(req0, req1);
        OWN0: begin
          if (!req1 && !req0) begin
            state_next = IDLE;
          end else if (req1 && (!req0 || hold >= HOLD_MIN)) begin
`ifdef SEG_BLANK_GAP_EN
            state_next  = GAP;
            target_next = OWN1;
`else
            state_next = OWN1;
`endif
          end
        end
        OWN1: begin
          if (!req1 && !req0) begin
            state_next = IDLE;
          end else if (req0 && (!req1 || hold >= HOLD_MIN)) begin
`ifdef SEG_BLANK_GAP_EN
            state_next  = GAP;
            target_next = OWN0;
`else
            state_next = OWN0;
`endif
          end
        end
`ifdef SEG_BLANK_GAP_EN
        GAP: begin
          if ((target == OWN1 && req1) || (target == OWN0 && req0))
            state_next = target;
          else
            state_next = idle_pick(req0, req1);
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // Hold clears on any ownership change and counts frames spent as owner.
  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (frame_end) begin
      if (state_next != state)
        hold <= '0;
      else if ((state == OWN0 || state == OWN1) && hold != 8'hFF)
        hold <= hold + 8'd1;
    end
  end

  // Digits follow the incoming owner so the new grant and its first digit line up.
  always_comb begin
    blank      = 1'b1;
    owner_data = data0;
    if (state_next == OWN0) begin
      blank      = 1'b0;
      owner_data = data0;
    end else if (state_next == OWN1) begin
      blank      = 1'b0;
      owner_data = data1;
    end
  end

  assign owner_byte = owner_data[{idx_next, 3'b000} +: 8];

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= 4'b1111;
      seg  <= 8'hFF;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end else begin
      gnt0 <= (state_next == OWN0);
      gnt1 <= (state_next == OWN1);
      if (tick) begin
        an  <= blank ? 4'b1111 : ~(4'b0001 << idx_next);
        seg <= blank ? 8'hFF : owner_byte;
      end
    end
  end

endmodule
